gem_trg_link_seq: RTL and testbench

GEM_TRG_LINK_SEQ -- requirements
Module: gem_trg_link_seq

---
 rtl/gem_link_pkg.sv | 33 +++
 rtl/gem_link_timer.sv | 27 ++
 rtl/gem_trg_link_seq.sv | 176 +++++++++++++++++
 tb/tb_gem_trg_link_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gem_link_pkg.sv
// Shared definitions for the GEM trigger-link TX bring-up sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state encoding, state-code constants, simulation timeout and
// the comma fill word the link transmits while TRG_DATA_RST is high.
package gem_link_pkg;

  // State codes as exposed on LINK_STATE.
  localparam logic [2:0] LS_PLL_RST   = 3'd0;
  localparam logic [2:0] LS_WAIT_LOCK = 3'd1;
  localparam logic [2:0] LS_GTX_RST   = 3'd2;
  localparam logic [2:0] LS_WAIT_DONE = 3'd3;
  localparam logic [2:0] LS_WAIT_SYNC = 3'd4;
  localparam logic [2:0] LS_ALIGN     = 3'd5;
  localparam logic [2:0] LS_READY     = 3'd6;

  typedef enum logic [2:0] {
    ST_PLL_RST   = LS_PLL_RST,
    ST_WAIT_LOCK = LS_WAIT_LOCK,
    ST_GTX_RST   = LS_GTX_RST,
    ST_WAIT_DONE = LS_WAIT_DONE,
    ST_WAIT_SYNC = LS_WAIT_SYNC,
    ST_ALIGN     = LS_ALIGN,
    ST_READY     = LS_READY
  } link_state_e;

  // Per-state wait limit used when SIM_SPEEDUP is nonzero.
  localparam int unsigned SIM_TIMEOUT_CYCLES = 64;

  // Idle word sent on the link while data is held in reset.
  localparam logic [31:0] COMMA_WORD = 32'h50BC50BC;

endpackage

// File: rtl/gem_link_timer.sv
// Shared per-state timer: 16-bit up-counter with terminal-count compare.
// Latency: o_tc is combinational from the count register (count updates 1 cycle after clr/en).
// Backpressure: none; i_clr dominates i_en.
// Ports: i_clk, i_rst_n (sync, active-low), i_clr (restart from 0), i_en (count),
//        i_tc_val (terminal value), o_tc (count == i_tc_val).
module gem_link_timer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [15:0] i_tc_val,
  output logic        o_tc
);

  logic [15:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/gem_trg_link_seq.sv
// GEM trigger-link TX bring-up: PLL reset, GTX reset, phase sync, comma alignment, then data.
// Latency: every output is registered and follows the state register by 1 cycle.
// Backpressure: none; status inputs are sampled every cycle, FORCE_RESYNC is a 1-cycle pulse.
// Ports: TRG_CLK80 (clock), TRG_RST_N (sync active-low reset), TRG_TX_PLL_LOCK,
//        TRG_TXRESETDONE, TX_SYNC_DONE, FORCE_RESYNC, CLR_CNT in; TRG_TX_PLLRST,
//        TRG_GTXTXRST, TRG_DATA_RST, LINK_READY, LINK_STATE[2:0], RETRY_CNT[7:0] out.
// Build option: define GEM_LINK_RETRY_CNT_EN to implement RETRY_CNT; otherwise it reads 0.
module gem_trg_link_seq
  import gem_link_pkg::*;
#(
  parameter int SIM_SPEEDUP    = 0,
  parameter int PLLRST_CYCLES  = 16,
  parameter int GTXRST_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ALIGN_CYCLES   = 256
) (
  input  logic       TRG_CLK80,
  input  logic       TRG_RST_N,
  input  logic       TRG_TX_PLL_LOCK,
  input  logic       TRG_TXRESETDONE,
  input  logic       TX_SYNC_DONE,
  input  logic       FORCE_RESYNC,
  input  logic       CLR_CNT,
  output logic       TRG_TX_PLLRST,
  output logic       TRG_GTXTXRST,
  output logic       TRG_DATA_RST,
  output logic       LINK_READY,
  output logic [2:0] LINK_STATE,
  output logic [7:0] RETRY_CNT
);

  localparam int          TO_EFF     = (SIM_SPEEDUP != 0) ? int'(SIM_TIMEOUT_CYCLES) : TIMEOUT_CYCLES;
  // The timer holds value N-1 during the last cycle of an N-cycle state.
  localparam logic [15:0] TC_PLLRST  = 16'(PLLRST_CYCLES - 1);
  localparam logic [15:0] TC_GTXRST  = 16'(GTXRST_CYCLES - 1);
  localparam logic [15:0] TC_ALIGN   = 16'(ALIGN_CYCLES - 1);
  localparam logic [15:0] TC_TIMEOUT = 16'(TO_EFF - 1);

  link_state_e r_state;
  link_state_e w_nxt;
  logic        r_lock_lo;   // lock was low last cycle while READY
  logic        r_pllrst;
  logic        r_gtxrst;
  logic        r_data_rst;
  logic        r_link_rdy;
  logic [2:0]  r_link_state;
  logic        w_tc;
  logic        w_inc;       // timeout or lock-loss restart this cycle
  logic [15:0] w_tc_val;

  always_comb begin
    case (r_state)
      ST_PLL_RST: w_tc_val = TC_PLLRST;
      ST_GTX_RST: w_tc_val = TC_GTXRST;
      ST_ALIGN:   w_tc_val = TC_ALIGN;
      default:    w_tc_val = TC_TIMEOUT;
    endcase
  end

  // Timer restarts on every state change; it is idle while READY.
  gem_link_timer u_timer (
    .i_clk    (TRG_CLK80),
    .i_rst_n  (TRG_RST_N),
    .i_clr    (w_nxt != r_state),
    .i_en     (r_state != ST_READY),
    .i_tc_val (w_tc_val),
    .o_tc     (w_tc)
  );

  always_comb begin
    w_nxt = r_state;
    w_inc = 1'b0;
    case (r_state)
      ST_PLL_RST: begin
        if (w_tc) w_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (TRG_TX_PLL_LOCK) begin
          w_nxt = ST_GTX_RST;
        end else if (w_tc) begin
          w_nxt = ST_PLL_RST;
          w_inc = 1'b1;
        end
      end
      ST_GTX_RST: begin
        if (w_tc) w_nxt = ST_WAIT_DONE;
      end
      // A resync request wins over progress and timeout; it never counts as a retry.
      ST_WAIT_DONE: begin
        if (FORCE_RESYNC) begin
          w_nxt = ST_GTX_RST;
        end else if (TRG_TXRESETDONE) begin
          w_nxt = ST_WAIT_SYNC;
        end else if (w_tc) begin
          w_nxt = ST_GTX_RST;
          w_inc = 1'b1;
        end
      end
      ST_WAIT_SYNC: begin
        if (FORCE_RESYNC) begin
          w_nxt = ST_GTX_RST;
        end else if (TX_SYNC_DONE) begin
          w_nxt = ST_ALIGN;
        end else if (w_tc) begin
          w_nxt = ST_GTX_RST;
          w_inc = 1'b1;
        end
      end
      ST_ALIGN: begin
        if (FORCE_RESYNC) begin
          w_nxt = ST_GTX_RST;
        end else if (w_tc) begin
          w_nxt = ST_READY;
        end
      end
      ST_READY: begin
        // Lock must be low on two consecutive samples; lock loss beats resync.
        if (!TRG_TX_PLL_LOCK && r_lock_lo) begin
          w_nxt = ST_PLL_RST;
          w_inc = 1'b1;
        end else if (FORCE_RESYNC) begin
          w_nxt = ST_GTX_RST;
        end
      end
      default: w_nxt = ST_PLL_RST;
    endcase
  end

  // GTX TX reset stays asserted until the PLL has locked and the GTX reset pulse is done.
  always_ff @(posedge TRG_CLK80) begin
    if (!TRG_RST_N) begin
      r_state      <= ST_PLL_RST;
      r_lock_lo    <= 1'b0;
      r_pllrst     <= 1'b1;
      r_gtxrst     <= 1'b1;
      r_data_rst   <= 1'b1;
      r_link_rdy   <= 1'b0;
      r_link_state <= LS_PLL_RST;
    end else begin
      r_state      <= w_nxt;
      r_lock_lo    <= (r_state == ST_READY) && !TRG_TX_PLL_LOCK;
      r_pllrst     <= (r_state == ST_PLL_RST);
      r_gtxrst     <= (r_state == ST_PLL_RST) || (r_state == ST_WAIT_LOCK) ||
                      (r_state == ST_GTX_RST);
      r_data_rst   <= (r_state != ST_READY);
      r_link_rdy   <= (r_state == ST_READY);
      r_link_state <= r_state;
    end
  end

  assign TRG_TX_PLLRST = r_pllrst;
  assign TRG_GTXTXRST  = r_gtxrst;
  assign TRG_DATA_RST  = r_data_rst;
  assign LINK_READY    = r_link_rdy;
  assign LINK_STATE    = r_link_state;

`ifdef GEM_LINK_RETRY_CNT_EN
  logic [7:0] r_retry_cnt;

  // Clear dominates a same-cycle increment; count saturates at 255.
  always_ff @(posedge TRG_CLK80) begin
    if (!TRG_RST_N || CLR_CNT) begin
      r_retry_cnt <= '0;
    end else if (w_inc && (r_retry_cnt != 8'hFF)) begin
      r_retry_cnt <= r_retry_cnt + 8'd1;
    end
  end

  assign RETRY_CNT = r_retry_cnt;
`else
  logic w_unused;
  assign w_unused  = CLR_CNT ^ w_inc;
  assign RETRY_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_gem_trg_link_seq.sv
// Scoreboard bench for gem_trg_link_seq (SIM_SPEEDUP=1, ALIGN_CYCLES=16).
// Stimulus pushes cycle-stamped expected output snapshots; a negedge monitor pops and compares.
module tb_gem_trg_link_seq;

  logic       clk = 1'b0;
  logic       rst_n, lock, rdone, sdone, force_rs, clr;
  logic       pllrst, gtxrst, drst, lrdy;
  logic [2:0] lstate;
  logic [7:0] rcnt;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       end_req = 1'b0;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t q[$];

  gem_trg_link_seq #(
    .SIM_SPEEDUP  (1),
    .ALIGN_CYCLES (16)
  ) dut (
    .TRG_CLK80       (clk),
    .TRG_RST_N       (rst_n),
    .TRG_TX_PLL_LOCK (lock),
    .TRG_TXRESETDONE (rdone),
    .TX_SYNC_DONE    (sdone),
    .FORCE_RESYNC    (force_rs),
    .CLR_CNT         (clr),
    .TRG_TX_PLLRST   (pllrst),
    .TRG_GTXTXRST    (gtxrst),
    .TRG_DATA_RST    (drst),
    .LINK_READY      (lrdy),
    .LINK_STATE      (lstate),
    .RETRY_CNT       (rcnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected retry count: counter only exists when the build option is on.
  function automatic logic [7:0] xc(input int c);
`ifdef GEM_LINK_RETRY_CNT_EN
    return 8'(c);
`else
    return (c == -1) ? 8'd1 : 8'd0;
`endif
  endfunction

  // {pllrst, gtxrst, data_rst, link_ready} implied by a state code.
  function automatic logic [3:0] outs_of(input logic [2:0] s);
    logic [3:0] o;
    o[3] = (s == 3'd0);
    o[2] = (s <= 3'd2);
    o[1] = (s != 3'd6);
    o[0] = (s == 3'd6);
    return o;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input int d, input logic [2:0] s, input int c, input string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.st   = s;
    e.cnt  = xc(c);
    e.name = nm;
    q.push_back(e);
  endtask

  // Monitor
  exp_t        m_e;
  logic [14:0] m_exp, m_act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      n_chk++;
      if (m_e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", m_e.name, m_e.cyc, cyc);
      end else begin
        m_exp = {m_e.st, outs_of(m_e.st), m_e.cnt};
        m_act = {lstate, pllrst, gtxrst, drst, lrdy, rcnt};
        if (m_act !== m_exp) begin
          n_fail++;
          $display("FAIL %s @%0d: got st=%0d pll/gtx/drst/rdy=%b cnt=%0d, want st=%0d pll/gtx/drst/rdy=%b cnt=%0d",
                   m_e.name, cyc, m_act[14:12], m_act[11:8], m_act[7:0],
                   m_exp[14:12], m_exp[11:8], m_exp[7:0]);
        end
      end
    end
    if (end_req) begin
      while (q.size() > 0) begin
        m_e = q.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never reached (now %0d)", m_e.name, m_e.cyc, cyc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; lock = 1'b0; rdone = 1'b0; sdone = 1'b0; force_rs = 1'b0; clr = 1'b0;
    repeat (3) step();
    push(1, 3'd0, 0, "reset_values");
    step();
    rst_n = 1'b1; rdone = 1'b1; sdone = 1'b1;

    // Nominal: 16 PLL reset, 5 WAIT_LOCK, 8 GTX reset, 1+1 waits, 16 ALIGN, +1 output register.
    push(1,  3'd0, 0, "nom_pllrst_start");
    push(16, 3'd0, 0, "nom_pllrst_end");
    push(17, 3'd1, 0, "nom_wait_lock");
    push(21, 3'd1, 0, "nom_wait_lock_end");
    push(22, 3'd2, 0, "nom_gtx_rst");
    push(29, 3'd2, 0, "nom_gtx_rst_end");
    push(30, 3'd3, 0, "nom_wait_done");
    push(31, 3'd4, 0, "nom_wait_sync");
    push(32, 3'd5, 0, "nom_align");
    push(47, 3'd5, 0, "nom_align_end");
    push(48, 3'd6, 0, "nom_ready_rise");
    repeat (20) step();
    lock = 1'b1;
    repeat (32) step();

    // One-cycle lock glitch in READY is ignored.
    push(2, 3'd6, 0, "glitch1_hold_a");
    push(3, 3'd6, 0, "glitch1_hold_b");
    push(4, 3'd6, 0, "glitch1_hold_c");
    lock = 1'b0;
    step();
    lock = 1'b1;
    repeat (5) step();

    // Two-cycle lock loss restarts from PLL_RST and counts a retry.
    push(2,  3'd6, 1, "lockloss_cnt");
    push(3,  3'd0, 1, "lockloss_pllrst");
    push(45, 3'd5, 1, "lockloss_realign");
    push(46, 3'd6, 1, "lockloss_ready");
    lock = 1'b0;
    step();
    step();
    lock = 1'b1;
    repeat (50) step();

    // FORCE_RESYNC in READY: GTX_RST, no retry count.
    push(1,  3'd6, 1, "resync_pre");
    push(2,  3'd2, 1, "resync_gtx_rst");
    push(27, 3'd5, 1, "resync_align");
    push(28, 3'd6, 1, "resync_ready");
    force_rs = 1'b1;
    step();
    force_rs = 1'b0;
    repeat (31) step();

    // Lock loss and resync together (lock loss wins), then lock held low:
    // WAIT_LOCK times out every 80 cycles, count saturates, CLR_CNT wins over increment,
    // then a one-cycle reset pulse during ALIGN.
    push(2,     3'd6, 2,   "prio_cnt");
    push(3,     3'd0, 2,   "prio_pllrst");
    push(18,    3'd0, 2,   "to_pllrst_end");
    push(19,    3'd1, 2,   "to_wait_lock");
    push(82,    3'd1, 3,   "to1_cnt");
    push(83,    3'd0, 3,   "to1_pllrst");
    push(162,   3'd1, 4,   "to2_cnt");
    push(163,   3'd0, 4,   "to2_pllrst");
    push(24003, 3'd0, 255, "to300_saturated");
    push(24081, 3'd1, 255, "clr_pre");
    push(24082, 3'd1, 0,   "clr_with_inc");
    push(24083, 3'd0, 0,   "clr_after");
    push(24163, 3'd0, 1,   "clr_then_inc");
    push(24194, 3'd5, 1,   "rstpulse_pre_align");
    push(24195, 3'd0, 0,   "rstpulse_reset_vals");
    push(24196, 3'd0, 0,   "rstpulse_pllrst");
    push(24211, 3'd0, 0,   "rstpulse_pllrst_end");
    push(24212, 3'd1, 0,   "rstpulse_wait_lock");
    push(24238, 3'd5, 0,   "rstpulse_align");
    push(24239, 3'd6, 0,   "rstpulse_ready");
    lock = 1'b0;
    step();
    force_rs = 1'b1;
    step();
    force_rs = 1'b0;
    repeat (24079) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (81) step();
    lock = 1'b1;
    repeat (31) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (48) step();

    for (int i = 0; i < 100 && q.size() > 0; i++) step();
    end_req = 1'b1;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
